// File: rtl/mxn_elastic_pipeline.sv
// M-bit, N-stage elastic pipeline: valid/ready at both ends, bubbles collapse under stall.
// Occupancy counter and sticky stall flag are provided for debug.

module mxn_elastic_pipeline_stage #(
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         acc,
  input  logic         src_vld,
  input  logic [M-1:0] src_dat,
  output logic         vld,
  output logic [M-1:0] dat
);
  // Data only loads on a real word, so an emptied stage keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (acc) begin
      vld <= src_vld;
      if (src_vld) dat <= src_dat;
    end
  end
endmodule

module mxn_elastic_pipeline #(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [M-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [M-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy,
  output logic          stalled
);
  // Index 0 is the upstream writer; 1..N are the stage registers.
  logic [N:0]          vld_pipe;
  logic [N:0][M-1:0]   dat_pipe;
  logic [N+1:1]        acc;
  logic                in_xfer, out_xfer;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_data;

  // A stage accepts when it is empty or its word moves on; ~v | (v & a) == ~v | a.
  always_comb begin
    acc      = '0;
    acc[N+1] = out_ready;
    for (int k = N; k >= 1; k--)
      acc[k] = ~vld_pipe[k] | acc[k+1];
  end

  for (genvar k = 1; k <= N; k++) begin : g_stg
    mxn_elastic_pipeline_stage #(.M(M)) u_stg (
      .clk     (clk),
      .rst     (rst),
      .acc     (acc[k]),
      .src_vld (vld_pipe[k-1]),
      .src_dat (dat_pipe[k-1]),
      .vld     (vld_pipe[k]),
      .dat     (dat_pipe[k])
    );
  end

  assign in_ready  = acc[1];
  assign out_valid = vld_pipe[N];
  assign out_data  = dat_pipe[N];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      stalled   <= 1'b0;
    end else begin
      occupancy <= occupancy + CW'(in_xfer) - CW'(out_xfer);
      if (out_valid & ~out_ready) stalled <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Randomized plus directed bench for mxn_elastic_pipeline against a word-position queue model.
module tb_mxn_elastic_pipeline;
  localparam int M = 3, N = 4, CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic          stalled;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: words in flight, oldest first, each with the stage it sits in (1..N).
  int           pos[$];
  logic [M-1:0] wq[$];
  bit           stk;

  mxn_elastic_pipeline #(.M(M), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (pos.size() < N) || out_ready;
  endfunction

  function automatic bit m_ovalid();
    return (pos.size() > 0) && (pos[0] == N);
  endfunction

  task automatic m_clear();
    pos.delete();
    wq.delete();
    stk = 0;
  endtask

  // Advance model one edge: head may leave; each word moves forward if the slot ahead frees up.
  task automatic m_edge();
    bit rdy, ov;
    int bound, np;
    rdy = m_ready();
    ov  = m_ovalid();
    if (ov && !out_ready) stk = 1;
    if (ov && out_ready) begin
      void'(pos.pop_front());
      void'(wq.pop_front());
    end
    bound = N + 1;
    foreach (pos[i]) begin
      np = pos[i] + 1;
      if (np > bound - 1) np = bound - 1;
      if (np > N) np = N;
      pos[i] = np;
      bound  = np;
    end
    if (in_valid && rdy) begin
      pos.push_back(1);
      wq.push_back(in_data);
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, m_ovalid());
    if (m_ovalid()) chk("out_data", out_data, wq[0]);
    chk("occupancy", occupancy, pos.size());
    chk("stalled", stalled, stk);
  endtask

  // One cycle: drive at negedge, check, let the edge happen, return at next negedge.
  task automatic cyc(input logic iv, input logic [M-1:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stalled", stalled, 0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [M-1:0] seq [5];
    seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0;
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_occupancy", occupancy, 0);
    rst = 1'b0;
    #1;
    chk("init_in_ready", in_ready, 1);
    @(negedge clk);

    // Mid-stream reset with three words held
    cyc(1, 3'b101, 0); cyc(1, 3'b110, 0); cyc(1, 3'b011, 0);
    cyc(0, 3'b000, 0); cyc(0, 3'b000, 0);
    async_reset();
    @(negedge clk);

    // Streaming
    cyc(1, 3'b001, 1); cyc(1, 3'b010, 1); cyc(1, 3'b111, 1);
    repeat (5) cyc(0, 3'b000, 1);

    // Fill under stall, then pass-through from full
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0);
    chk("fill_occupancy", occupancy, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_data", out_data, 3'b001);
    cyc(1, 3'b110, 1);
    chk("pass_occupancy", occupancy, 4);
    for (int i = 0; i < 6; i++) cyc(0, 3'b000, 1);

    // Bubble collapse: alternate-cycle writes under stall
    for (int i = 0; i < 10; i++) cyc(i % 2 == 0, 3'(i + 1), 0);
    chk("bubble_occupancy", occupancy, 4);
    #1 chk("bubble_in_ready", in_ready, 0);

    // Drain
    for (int i = 0; i < 6; i++) cyc(0, 3'b000, 1);
    chk("drain_stalled", stalled, 1);

    // Randomized traffic with stall-biased and flow-biased stretches
    for (int blk = 0; blk < 8; blk++) begin
      int rbias = (blk % 2 == 0) ? 4 : 1;
      for (int i = 0; i < 50; i++)
        cyc($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, rbias) != 0);
      if (blk == 4) begin
        async_reset();
        @(negedge clk);
      end
    end
    for (int i = 0; i < 8; i++) cyc(0, 3'b000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mxn_elastic_pipeline.md
Name: mxn_elastic_pipeline

Overview:
- M-bit wide, N-stage pipeline with valid/ready flow control at both ends.
- Sits at the consuming end of a free-running M×N datapath pipeline. It lets the downstream reader stall the stream without losing or duplicating words.
- Empty slots (bubbles) collapse while the pipeline is stalled, so every stage can hold data.
- Provides an occupancy count and a sticky stall flag for debug.

Parameters:
- M, 3, data width in bits.
- N, 4, number of pipeline stages (N >= 2).
- CW, 3, occupancy counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  M  word offered by the upstream writer.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  pipeline accepts a word this cycle.
- out_data  output  M  word presented to the downstream reader (from stage N).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream reader accepts out_data this cycle.
- occupancy  output  CW  number of valid stages, 0..N.
- stalled  output  1  sticky flag: set when out_valid & ~out_ready; cleared only by rst.

Behaviour:
- State per stage k=1..N: valid bit v[k] and data register d[k]. Stage N drives out_valid=v[N] and out_data=d[N].
- Reset (async, rst=1): all v[k]=0, all d[k]=0, occupancy=0, stalled=0. Therefore out_valid=0, out_data=0, and in_ready=1 as soon as rst is deasserted.
- Asserting rst mid-operation discards all in-flight words immediately, without waiting for a clock edge.
- Combinational ready chain, evaluated from stage N down to stage 1:
  - mv[N] = v[N] & out_ready
  - acc[k] = ~v[k] | mv[k]
  - mv[k] = v[k] & acc[k+1] for k<N
  - in_ready = acc[1]
  - in_ready depends combinationally on out_ready. This is intentional; there is no skid buffer.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- On each rising clk edge, for each stage k:
  - if acc[k]: v[k] <= (k==1 ? in_valid : v[k-1] & ... i.e. mv[k-1]), and d[k] <= the incoming word when that source is valid;
  - otherwise v[k] and d[k] hold.
  - When a stage accepts nothing (source not valid), d[k] holds its old value and only v[k] clears.
- Latency: with out_ready held at 1 and no stalls, a word accepted at edge t appears on out_data with out_valid=1 after edge t+N-1 and is consumed at edge t+N.
  - Throughput is 1 word/cycle.
- Stall: while out_valid=1 and out_ready=0, out_data is stable and stage N holds its word.
  - Upstream stages keep advancing into empty slots until all N stages are valid; then in_ready=0.
- Simultaneous accept at a full pipeline: occupancy=N with out_ready=1 and in_valid=1 gives in_ready=1. One word leaves and one enters in the same cycle; occupancy stays N.
- occupancy is registered:
  - occupancy <= occupancy + in_xfer - out_xfer
  - it never exceeds N and never underflows; both are guaranteed by the handshake.
- No word is ever dropped or duplicated; output order equals input order.
- An X on clk is not a valid edge; the only state-update event is a 0→1 transition.
- in_data is ignored when in_valid=0. out_data is don't-care when out_valid=0, but holds its last value.

Test Plan (M=3, N=4):
- Reset:
  - Assert rst mid-stream with 3 words held → out_valid=0, out_data=3'b000, occupancy=0, stalled=0 immediately, before any clock edge.
  - Release rst → in_ready=1.
- Streaming:
  - out_ready=1; send 3'b001, 3'b010, 3'b111 on consecutive edges → same values appear on out_data in order.
  - First word is valid after the 3rd edge following its acceptance; no gaps between words.
- Fill under stall:
  - out_ready=0; send 5 words 3'b001..3'b101 → first 4 accepted, in_ready=0 on the 5th, occupancy=4, stalled=1, out_data=3'b001 held stable.
- Full pass-through:
  - From the full state, set out_ready=1 and in_valid=1 with 3'b110 → occupancy stays 4; outputs appear in order 3'b001, 3'b010, 3'b011, 3'b100, 3'b110.
- Bubble collapse:
  - Send words on alternate cycles with out_ready=0 → after 4 accepted words, occupancy=4 and in_ready=0; no bubble remains in any stage.
- Drain:
  - Stop input and set out_ready=1 → occupancy counts down 4,3,2,1,0; out_valid falls the cycle after the last transfer; stalled remains 1 until rst.
